// File: rtl/psk_symbol_mapper_if.sv
// rtl/psk_symbol_mapper_if.sv - symbol stream in / I-Q stream out bundle for the PSK mapper
interface psk_symbol_mapper_if #(
    parameter int BYTES    = 1,
    parameter int IQ_WIDTH = 12
);
    logic [BYTES*8-1:0]         I_tdata;
    logic                       I_tvalid;
    logic                       I_tready;
    logic                       I_tlast;
    logic                       I_tuser;
    logic signed [IQ_WIDTH-1:0] O_i;
    logic signed [IQ_WIDTH-1:0] O_q;
    logic                       O_vld;
    logic                       O_ready;
    logic                       O_last;
    logic                       O_bpsk;

    modport slave (
        input  I_tdata, I_tvalid, I_tlast, I_tuser, O_ready,
        output I_tready, O_i, O_q, O_vld, O_last, O_bpsk
    );

    modport master (
        output I_tdata, I_tvalid, I_tlast, I_tuser, O_ready,
        input  I_tready, O_i, O_q, O_vld, O_last, O_bpsk
    );
endinterface

// File: rtl/psk_symbol_mapper.sv
// rtl/psk_symbol_mapper.sv - BPSK/QPSK symbol to signed I/Q mapper with guard insertion
module psk_symbol_mapper #(
    parameter int BYTES    = 1,
    parameter int IQ_WIDTH = 12,
    parameter int AMP_BPSK = 2047,
    parameter int AMP_QPSK = 1447,
    parameter int GUARD    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    psk_symbol_mapper_if.slave  bus,
    output logic [15:0]         sym_cnt,
    output logic                pkt_done
);
    typedef enum logic [1:0] {IDLE, RUN, GUARD_ST} state_t;

    localparam logic signed [IQ_WIDTH-1:0] B_POS = IQ_WIDTH'(AMP_BPSK);
    localparam logic signed [IQ_WIDTH-1:0] B_NEG = -B_POS;
    localparam logic signed [IQ_WIDTH-1:0] Q_POS = IQ_WIDTH'(AMP_QPSK);
    localparam logic signed [IQ_WIDTH-1:0] Q_NEG = -Q_POS;
    localparam logic [7:0] GUARD_LAST = (GUARD == 0) ? 8'd0 : 8'(GUARD - 1);
    localparam bit         NO_GUARD   = (GUARD == 0);

    state_t                     r_state, w_state_n;
    logic signed [IQ_WIDTH-1:0] r_i, r_q, w_i_n, w_q_n, w_map_i, w_map_q;
    logic                       r_vld, r_last, r_bpsk, r_gsym, r_pkt_done;
    logic                       w_vld_n, w_last_n, w_bpsk_n, w_gsym_n, w_pkt_done_n;
    logic [15:0]                r_sym_cnt, w_sym_cnt_n;
    logic [7:0]                 r_guard_cnt, w_guard_cnt_n;
    logic                       w_slot_free, w_tready, w_in_xfer, w_out_xfer;

    assign w_slot_free  = ~r_vld | bus.O_ready;
    assign w_tready     = w_slot_free & (r_state != GUARD_ST);
    assign w_in_xfer    = bus.I_tvalid & w_tready;
    assign w_out_xfer   = r_vld & bus.O_ready;

    assign bus.I_tready = w_tready;
    assign bus.O_i      = r_i;
    assign bus.O_q      = r_q;
    assign bus.O_vld    = r_vld;
    assign bus.O_last   = r_last;
    assign bus.O_bpsk   = r_bpsk;
    assign sym_cnt      = r_sym_cnt;
    assign pkt_done     = r_pkt_done;

    always_comb begin
        w_map_i = '0;
        w_map_q = '0;
        if (bus.I_tuser) begin
            w_map_i = bus.I_tdata[0] ? B_POS : B_NEG;
        end else begin
            w_map_i = bus.I_tdata[1] ? Q_POS : Q_NEG;
            w_map_q = bus.I_tdata[0] ? Q_POS : Q_NEG;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_i_n         = r_i;
        w_q_n         = r_q;
        w_vld_n       = r_vld;
        w_last_n      = r_last;
        w_bpsk_n      = r_bpsk;
        w_gsym_n      = r_gsym;
        w_sym_cnt_n   = r_sym_cnt;
        w_guard_cnt_n = r_guard_cnt;
        w_pkt_done_n  = w_out_xfer & r_last;

        case (r_state)
            GUARD_ST: begin
                // r_gsym tells a draining guard symbol apart from the tlast data symbol
                if (w_slot_free) begin
                    w_i_n    = '0;
                    w_q_n    = '0;
                    w_bpsk_n = 1'b1;
                    w_vld_n  = 1'b1;
                    w_gsym_n = 1'b1;
                    if (r_vld && r_gsym) begin
                        w_guard_cnt_n = r_guard_cnt + 8'd1;
                        if (r_last) begin
                            w_vld_n   = 1'b0;
                            w_last_n  = 1'b0;
                            w_gsym_n  = 1'b0;
                            w_state_n = IDLE;
                        end else begin
                            w_last_n = ((r_guard_cnt + 8'd1) == GUARD_LAST);
                        end
                    end else begin
                        w_last_n = (r_guard_cnt == GUARD_LAST);
                    end
                end
            end
            default: begin
                if (w_in_xfer) begin
                    w_i_n    = w_map_i;
                    w_q_n    = w_map_q;
                    w_vld_n  = 1'b1;
                    w_bpsk_n = bus.I_tuser;
                    w_gsym_n = 1'b0;
                    w_last_n = bus.I_tlast & NO_GUARD;
                    if (r_state == IDLE)
                        w_sym_cnt_n = 16'd1;
                    else if (r_sym_cnt != 16'hFFFF)
                        w_sym_cnt_n = r_sym_cnt + 16'd1;
                    if (bus.I_tlast) begin
                        w_state_n     = NO_GUARD ? IDLE : GUARD_ST;
                        w_guard_cnt_n = 8'd0;
                    end else begin
                        w_state_n = RUN;
                    end
                end else if (w_out_xfer) begin
                    w_vld_n  = 1'b0;
                    w_last_n = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_q         <= '0;
            r_vld       <= 1'b0;
            r_last      <= 1'b0;
            r_bpsk      <= 1'b1;
            r_gsym      <= 1'b0;
            r_sym_cnt   <= 16'd0;
            r_guard_cnt <= 8'd0;
            r_pkt_done  <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_i         <= w_i_n;
            r_q         <= w_q_n;
            r_vld       <= w_vld_n;
            r_last      <= w_last_n;
            r_bpsk      <= w_bpsk_n;
            r_gsym      <= w_gsym_n;
            r_sym_cnt   <= w_sym_cnt_n;
            r_guard_cnt <= w_guard_cnt_n;
            r_pkt_done  <= w_pkt_done_n;
        end
    end
endmodule

// File: tb/tb_psk_symbol_mapper.sv
// tb/tb_psk_symbol_mapper.sv - scoreboard bench for psk_symbol_mapper (GUARD=4 and GUARD=0)
module tb_psk_symbol_mapper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    psk_symbol_mapper_if #(.BYTES(1), .IQ_WIDTH(12)) if0 ();
    psk_symbol_mapper_if #(.BYTES(1), .IQ_WIDTH(12)) if1 ();
    logic [15:0] sc0, sc1;
    logic        pd0, pd1;

    psk_symbol_mapper #(.GUARD(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .sym_cnt(sc0), .pkt_done(pd0));
    psk_symbol_mapper #(.GUARD(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .sym_cnt(sc1), .pkt_done(pd1));

    typedef struct packed {
        logic signed [11:0] i;
        logic signed [11:0] q;
        logic               last;
        logic               bpsk;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass = 0, n_checks = 0;
    int   n_out0 = 0, n_out1 = 0, n_done0 = 0, n_done1 = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    endtask

    function automatic exp_t map_exp(input logic [7:0] d, input logic u, input logic l);
        exp_t e;
        if (u) begin
            e.i = d[0] ? 12'sd2047 : -12'sd2047;
            e.q = 12'sd0;
        end else begin
            e.i = d[1] ? 12'sd1447 : -12'sd1447;
            e.q = d[0] ? 12'sd1447 : -12'sd1447;
        end
        e.last = l;
        e.bpsk = u;
        return e;
    endfunction

    task automatic send1(input logic [7:0] d, input logic u, input logic l);
        bit ok = 0;
        exp_t g;
        q1.push_back(map_exp(d, u, 1'b0));
        if (l) for (int k = 0; k < 4; k++) begin
            g.i = 12'sd0; g.q = 12'sd0; g.bpsk = 1'b1; g.last = (k == 3);
            q1.push_back(g);
        end
        if1.I_tdata = d; if1.I_tuser = u; if1.I_tlast = l; if1.I_tvalid = 1'b1;
        for (int t = 0; t < 500 && !ok; t++) begin
            @(negedge clk); ok = if1.I_tready;
            @(posedge clk); #1;
        end
        if (!ok) chk(0, "send1_timeout", 0, 1);
        if1.I_tvalid = 1'b0;
    endtask

    task automatic send0(input logic [7:0] d, input logic u);
        bit ok = 0;
        q0.push_back(map_exp(d, u, 1'b1));
        if0.I_tdata = d; if0.I_tuser = u; if0.I_tlast = 1'b1; if0.I_tvalid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk); ok = if0.I_tready;
            @(posedge clk); #1;
        end
        if (!ok) chk(0, "send0_timeout", 0, 1);
        if0.I_tvalid = 1'b0;
    endtask

    task automatic drain1();
        bit done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(posedge clk); #1;
            done = (q1.size() == 0) && !if1.O_vld;
        end
        chk(done, "drain1", q1.size(), 0);
    endtask

    // Monitor for the GUARD=4 instance: scoreboard pop, hold-while-stalled, pkt_done timing
    exp_t e1, held1;
    bit   stall1 = 0, ed1 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall1 = 0;
            ed1    = 0;
        end else begin
            chk(pd1 == ed1, "pkt_done1", int'(pd1), int'(ed1));
            if (pd1) n_done1++;
            if (stall1)
                chk(if1.O_vld && ({if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk} == held1), "hold1",
                    int'({if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk}), int'(held1));
            stall1 = 0;
            ed1    = 0;
            if (if1.O_vld && !if1.O_ready) begin
                stall1 = 1;
                held1  = {if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk};
                chk(!if1.I_tready, "tready_stall1", int'(if1.I_tready), 0);
            end
            if (if1.O_vld && if1.O_ready) begin
                n_out1++;
                if (q1.size() == 0) begin
                    chk(0, "unexpected_sym1", int'({if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk}), 0);
                end else begin
                    e1 = q1.pop_front();
                    chk({if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk} == e1, "sym1",
                        int'({if1.O_i, if1.O_q, if1.O_last, if1.O_bpsk}), int'(e1));
                end
                ed1 = if1.O_last;
            end
        end
    end

    exp_t e0;
    bit   ed0 = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            ed0 = 0;
        end else begin
            chk(pd0 == ed0, "pkt_done0", int'(pd0), int'(ed0));
            if (pd0) n_done0++;
            ed0 = 0;
            if (if0.O_vld && if0.O_ready) begin
                n_out0++;
                if (q0.size() == 0) begin
                    chk(0, "unexpected_sym0", int'({if0.O_i, if0.O_q, if0.O_last, if0.O_bpsk}), 0);
                end else begin
                    e0 = q0.pop_front();
                    chk({if0.O_i, if0.O_q, if0.O_last, if0.O_bpsk} == e0, "sym0",
                        int'({if0.O_i, if0.O_q, if0.O_last, if0.O_bpsk}), int'(e0));
                end
                ed0 = if0.O_last;
            end
        end
    end

    initial begin
        int        base;
        bit        hit;
        logic [3:0] pat;
        rst_n = 1'b0;
        if0.I_tvalid = 0; if0.I_tdata = 0; if0.I_tlast = 0; if0.I_tuser = 0; if0.O_ready = 1;
        if1.I_tvalid = 0; if1.I_tdata = 0; if1.I_tlast = 0; if1.I_tuser = 0; if1.O_ready = 1;
        #12;
        chk({if1.O_vld, if1.O_last, if1.O_bpsk, pd1} == 4'b0010, "reset_flags1",
            int'({if1.O_vld, if1.O_last, if1.O_bpsk, pd1}), 2);
        chk({if1.O_i, if1.O_q} == 24'd0, "reset_iq1", int'({if1.O_i, if1.O_q}), 0);
        chk(sc1 == 16'd0, "reset_symcnt1", int'(sc1), 0);
        chk({if0.O_vld, if0.O_bpsk, sc0} == 18'h10000, "reset_0", int'({if0.O_vld, if0.O_bpsk, sc0}), 'h10000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: BPSK 1,0,1
        send1(8'd1, 1, 0); send1(8'd0, 1, 0); send1(8'd1, 1, 1);
        drain1();
        chk(sc1 == 16'd3, "t1_symcnt", int'(sc1), 3);

        // T2: QPSK 00,01,10,11 with upper bits set to show they are ignored
        for (int k = 0; k < 4; k++) send1(8'(k) | 8'hFC, 0, k == 3);
        drain1();
        chk(sc1 == 16'd4, "t2_symcnt", int'(sc1), 4);

        // T3: O_ready pattern 1,0,0,1 during a 5-symbol packet
        pat = 4'b1001;
        fork
            for (int k = 0; k < 5; k++) send1(8'(k), k[0], k == 4);
            begin
                for (int k = 0; k < 16; k++) begin
                    if1.O_ready = pat[k % 4];
                    @(posedge clk); #1;
                end
                if1.O_ready = 1'b1;
            end
        join
        drain1();
        chk(sc1 == 16'd5, "t3_symcnt", int'(sc1), 5);

        // T4: GUARD=0, two back-to-back single-beat packets
        send0(8'd1, 1);
        chk(sc0 == 16'd1, "t4_symcnt_a", int'(sc0), 1);
        send0(8'd2, 0);
        chk(sc0 == 16'd1, "t4_symcnt_b", int'(sc0), 1);
        repeat (4) @(posedge clk);
        #1;
        chk(q0.size() == 0 && n_out0 == 2, "t4_out_count", n_out0, 2);
        chk(n_done0 == 2, "t4_pkt_done", n_done0, 2);

        // T5: reset after 2 guard symbols
        base = n_out1;
        hit  = 0;
        send1(8'd1, 1, 0); send1(8'd0, 1, 0); send1(8'd1, 1, 1);
        for (int t = 0; t < 100 && !hit; t++) begin
            @(posedge clk);
            hit = (n_out1 >= base + 5);
        end
        chk(hit, "t5_reach_guard", n_out1 - base, 5);
        #1 rst_n = 1'b0;
        #1;
        chk({if1.O_vld, if1.O_last, if1.O_bpsk, pd1} == 4'b0010, "t5_reset_flags",
            int'({if1.O_vld, if1.O_last, if1.O_bpsk, pd1}), 2);
        chk({if1.O_i, if1.O_q} == 24'd0 && sc1 == 16'd0, "t5_reset_data", int'(sc1), 0);
        chk(if1.I_tready == 1'b1, "t5_reset_tready", int'(if1.I_tready), 1);
        q1.delete();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send1(8'd1, 1, 0); send1(8'd0, 1, 0); send1(8'd1, 1, 1);
        drain1();
        chk(sc1 == 16'd3, "t5_symcnt", int'(sc1), 3);

        // T6: 320 BPSK header beats then 10 QPSK beats
        for (int k = 0; k < 320; k++) send1(8'(k), 1, 0);
        for (int k = 0; k < 10; k++) send1(8'(k), 0, k == 9);
        drain1();
        chk(sc1 == 16'd330, "t6_symcnt", int'(sc1), 330);

        repeat (2) @(posedge clk);
        #1;
        chk(n_done1 == 5, "pkt_done1_count", n_done1, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
